// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared constants and state encoding for the exception/ERET redirect controller.
package exc_redirect_ctrl_pkg;

    localparam logic [31:0] EXC_ENTRY = 32'hBFC00380;
    localparam int          OST_W_DEF = 2;

    typedef enum logic [1:0] {
        RC_IDLE  = 2'd0,
        RC_DRAIN = 2'd1,
        RC_REDIR = 2'd2
    } rc_state_e;

    // Exception beats ERET when both commit together.
    function automatic logic [31:0] redir_target(input logic exc, input logic [31:0] epc,
                                                 input logic [31:0] vec);
        return exc ? vec : epc;
    endfunction

endpackage

// File: rtl/exc_redirect_ctrl_fetch_ost_cnt.sv
// Outstanding-fetch counter plus the count of stale responses still to be dropped.
module fetch_ost_cnt #(
    parameter int OST_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_fire_i,
    input  logic             resp_fire_i,
    input  logic             load_i,
    output logic [OST_W-1:0] ost_cnt_o,
    output logic [OST_W-1:0] disc_cnt_o,
    output logic [OST_W-1:0] disc_nxt_o
);

    localparam logic [OST_W-1:0] OST_MAX = {OST_W{1'b1}};

    logic [OST_W-1:0] ost_q, ost_d;
    logic [OST_W-1:0] disc_q, disc_d;

    always_comb begin
        ost_d  = ost_q + OST_W'(req_fire_i) - OST_W'(resp_fire_i);
        disc_d = disc_q;
        // A response in the load cycle still belongs to the old stream.
        if (load_i)
            disc_d = ost_q - OST_W'(resp_fire_i);
        else if (resp_fire_i && disc_q != '0)
            disc_d = disc_q - OST_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ost_q  <= '0;
            disc_q <= '0;
        end else begin
            ost_q  <= ost_d;
            disc_q <= disc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(req_fire_i && ost_q == OST_MAX));
            assert (!(resp_fire_i && ost_q == '0));
        end
    end

    assign ost_cnt_o  = ost_q;
    assign disc_cnt_o = disc_q;
    assign disc_nxt_o = disc_d;

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Flushes the front end on exception/ERET commit, drains the bus, then hands IF one redirect PC.
module exc_redirect_ctrl
    import exc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_ENTRY,
    parameter int          OST_W      = OST_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exc_oc,
    input  logic             ec_eret,
    input  logic [31:0]      cp0_epc,
    input  logic             if_req_fire,
    input  logic             if_resp_fire,
    input  logic             dmem_busy,
    input  logic             redir_ready,
    output logic             flush_pipe,
    output logic             stall_front,
    output logic             inst_discard,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    output logic             busy,
    output logic [OST_W-1:0] ost_cnt
);

    rc_state_e        state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             evt;
    logic [OST_W-1:0] disc_cnt, disc_nxt;

    assign evt = (exc_oc | ec_eret) & (state_q == RC_IDLE) & ~reset;

    fetch_ost_cnt #(.OST_W(OST_W)) u_ost (
        .clk         (clk),
        .rst         (reset),
        .req_fire_i  (if_req_fire),
        .resp_fire_i (if_resp_fire),
        .load_i      (evt),
        .ost_cnt_o   (ost_cnt),
        .disc_cnt_o  (disc_cnt),
        .disc_nxt_o  (disc_nxt)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_pipe   = evt;
        busy         = (state_q != RC_IDLE);
        stall_front  = evt | (state_q != RC_IDLE);
        redir_valid  = (state_q == RC_REDIR);
        inst_discard = (disc_cnt != '0) | (evt & (ost_cnt != '0));
        unique case (state_q)
            RC_IDLE: if (evt) begin
                state_d = RC_DRAIN;
                pc_d    = redir_target(exc_oc, cp0_epc, EXC_VECTOR);
            end
            RC_DRAIN: if (disc_nxt == '0 && !dmem_busy) state_d = RC_REDIR;
            RC_REDIR: if (redir_ready) state_d = RC_IDLE;
            default:  state_d = RC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RC_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign redir_pc = pc_q;

    always_ff @(posedge clk) begin
        if (!reset) assert (!(if_req_fire && stall_front));
    end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench: stimulus pushes per-cycle and per-redirect expectations, monitors pop and compare.
module tb_exc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exc_oc = 1'b0, ec_eret = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        if_req_fire = 1'b0, if_resp_fire = 1'b0;
    logic        dmem_busy = 1'b0, redir_ready = 1'b0;
    logic        flush_pipe, stall_front, inst_discard, redir_valid, busy;
    logic [31:0] redir_pc;
    logic [1:0]  ost_cnt;

    exc_redirect_ctrl #(.EXC_VECTOR(32'hBFC00380), .OST_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .exc_oc       (exc_oc),
        .ec_eret      (ec_eret),
        .cp0_epc      (cp0_epc),
        .if_req_fire  (if_req_fire),
        .if_resp_fire (if_resp_fire),
        .dmem_busy    (dmem_busy),
        .redir_ready  (redir_ready),
        .flush_pipe   (flush_pipe),
        .stall_front  (stall_front),
        .inst_discard (inst_discard),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .busy         (busy),
        .ost_cnt      (ost_cnt)
    );

    always #5 clk = ~clk;

    // sig = {flush, stall, discard, redir_valid, busy, ost_cnt[1:0]}
    typedef struct {
        logic [6:0]  sig;
        logic        chk_pc;
        logic [31:0] pc;
        string       tag;
    } exp_t;

    exp_t        cyc_q[$];
    logic [31:0] redir_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [6:0]  act;
        logic [31:0] want;
        act = {flush_pipe, stall_front, inst_discard, redir_valid, busy, ost_cnt};
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            n_vec++;
            if (act !== e.sig || (e.chk_pc && redir_pc !== e.pc)) begin
                n_bad++;
                $display("FAIL %s: got sig=%b pc=%h, want sig=%b pc=%h",
                         e.tag, act, redir_pc, e.sig, e.pc);
            end
        end
        if (redir_valid === 1'b1 && redir_ready === 1'b1) begin
            n_vec++;
            if (redir_q.size() == 0) begin
                n_bad++;
                $display("FAIL redir_unexpected: got pc=%h, want no redirect", redir_pc);
            end else begin
                want = redir_q.pop_front();
                if (redir_pc !== want) begin
                    n_bad++;
                    $display("FAIL redir_pc: got %h, want %h", redir_pc, want);
                end
            end
        end
    end

    task automatic cyc(input logic exc, input logic eret, input logic req, input logic resp,
                       input logic dbusy, input logic rdy, input logic [6:0] sig,
                       input logic cpc, input logic [31:0] pc, input string tag);
        exp_t e;
        exc_oc = exc; ec_eret = eret; if_req_fire = req; if_resp_fire = resp;
        dmem_busy = dbusy; redir_ready = rdy;
        e.sig = sig; e.chk_pc = cpc; e.pc = pc; e.tag = tag;
        cyc_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] VEC = 32'hBFC00380;

    initial begin
        @(posedge clk); #1;
        cyc(0,0,0,0,0,0, 7'b00000_00, 1, 32'h0, "reset");
        reset = 1'b0;
        cyc(0,0,0,0,0,1, 7'b00000_00, 1, 32'h0, "idle");

        // exception, nothing outstanding, ready high
        redir_q.push_back(VEC);
        cyc(1,0,0,0,0,1, 7'b11000_00, 0, 0, "t1_event");
        cyc(0,0,0,0,0,1, 7'b01001_00, 0, 0, "t1_drain");
        cyc(0,0,0,0,0,1, 7'b01011_00, 1, VEC, "t1_redir");
        cyc(0,0,0,0,0,1, 7'b00000_00, 0, 0, "t1_idle");

        // ERET with two fetches outstanding, responses at t+3 and t+5
        cp0_epc = 32'h80001234;
        cyc(0,0,1,0,0,1, 7'b00000_00, 0, 0, "t2_req0");
        cyc(0,0,1,0,0,1, 7'b00000_01, 0, 0, "t2_req1");
        redir_q.push_back(32'h80001234);
        cyc(0,1,0,0,0,1, 7'b11100_10, 0, 0, "t2_event");
        cyc(0,0,0,0,0,1, 7'b01101_10, 0, 0, "t2_d1");
        cyc(0,0,0,0,0,1, 7'b01101_10, 0, 0, "t2_d2");
        cyc(0,0,0,1,0,1, 7'b01101_10, 0, 0, "t2_resp0");
        cyc(0,0,0,0,0,1, 7'b01101_01, 0, 0, "t2_d4");
        cyc(0,0,0,1,0,1, 7'b01101_01, 0, 0, "t2_resp1");
        cyc(0,0,0,0,0,1, 7'b01011_00, 1, 32'h80001234, "t2_redir");
        cyc(0,0,0,0,0,1, 7'b00000_00, 0, 0, "t2_idle");

        // exception and ERET together: exception vector wins
        cp0_epc = 32'h80000010;
        redir_q.push_back(VEC);
        cyc(1,1,0,0,0,1, 7'b11000_00, 0, 0, "t3_event");
        cyc(0,0,0,0,0,1, 7'b01001_00, 0, 0, "t3_drain");
        cyc(0,0,0,0,0,1, 7'b01011_00, 1, VEC, "t3_redir");
        cyc(0,0,0,0,0,1, 7'b00000_00, 0, 0, "t3_idle");

        // data side busy through t+6
        cp0_epc = 32'h80000020;
        redir_q.push_back(32'h80000020);
        cyc(0,1,0,0,1,1, 7'b11000_00, 0, 0, "t4_event");
        for (int i = 1; i <= 6; i++)
            cyc(0,0,0,0,1,1, 7'b01001_00, 0, 0, "t4_dbusy");
        cyc(0,0,0,0,0,1, 7'b01001_00, 0, 0, "t4_drain_last");
        cyc(0,0,0,0,0,1, 7'b01011_00, 1, 32'h80000020, "t4_redir");
        cyc(0,0,0,0,0,1, 7'b00000_00, 0, 0, "t4_idle");

        // ready withheld four cycles, second event ignored
        cp0_epc = 32'h80000030;
        redir_q.push_back(VEC);
        cyc(1,0,0,0,0,0, 7'b11000_00, 0, 0, "t5_event");
        cyc(0,0,0,0,0,0, 7'b01001_00, 0, 0, "t5_drain");
        cyc(0,0,0,0,0,0, 7'b01011_00, 1, VEC, "t5_hold0");
        cp0_epc = 32'h80000040;
        cyc(1,1,0,0,0,0, 7'b01011_00, 1, VEC, "t5_ignored");
        cyc(0,0,0,0,0,0, 7'b01011_00, 1, VEC, "t5_hold2");
        cyc(0,0,0,0,0,0, 7'b01011_00, 1, VEC, "t5_hold3");
        cyc(0,0,0,0,0,1, 7'b01011_00, 1, VEC, "t5_accept");
        cyc(0,0,0,0,0,1, 7'b00000_00, 1, VEC, "t5_idle");

        // reset while draining two stale responses
        cyc(0,0,1,0,0,1, 7'b00000_00, 0, 0, "t6_req0");
        cyc(0,0,1,0,0,1, 7'b00000_01, 0, 0, "t6_req1");
        cyc(1,0,0,0,0,1, 7'b11100_10, 0, 0, "t6_event");
        cyc(0,0,0,0,0,1, 7'b01101_10, 0, 0, "t6_drain");
        reset = 1'b1;
        cyc(0,0,0,1,0,1, 7'b00000_00, 1, 32'h0, "t6_async_rst");
        cyc(0,0,0,1,0,1, 7'b00000_00, 1, 32'h0, "t6_rst_resp");
        reset = 1'b0;
        cyc(0,0,0,0,0,1, 7'b00000_00, 1, 32'h0, "t6_post0");
        cyc(0,0,0,0,0,1, 7'b00000_00, 1, 32'h0, "t6_post1");

        @(negedge clk);
        n_vec++;
        if (redir_q.size() != 0 || cyc_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queues: got redir_left=%0d cyc_left=%0d, want 0 and 0",
                     redir_q.size(), cyc_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exc_redirect_ctrl.md
Name: exc_redirect_ctrl

Overview:
Sequences the front end after an exception or ERET commits in the EC stage.
- Flushes the pipeline and freezes new instruction fetches.
- Drains uncancellable in-flight bus transactions, discarding any stale instruction responses.
- Presents a single redirect PC to IF through a valid/ready handshake.
- Sits between the EC stage and the IF stage / instruction-bus interface.

Parameters:
EXC_VECTOR, 32'hBFC00380, exception entry PC (also defined in head.vh as `EXC_ENTRY`)
OST_W, 2, width of the outstanding-fetch counter; at most 2^OST_W-1 fetches in flight

Ports:
clk  in  1  clock
reset  in  1  one clock; reset is asynchronous and active-high
exc_oc  in  1  exception committed in EC this cycle
ec_eret  in  1  ERET committed in EC this cycle
cp0_epc  in  32  current EPC, used as the ERET target
if_req_fire  in  1  instruction address handshake completed
if_resp_fire  in  1  instruction data_ok returned
dmem_busy  in  1  data-side transaction in flight, cannot be cancelled
redir_ready  in  1  IF accepts the redirect
flush_pipe  out  1  one-cycle flush of IF/ID/EX/EC
stall_front  out  1  blocks new fetch requests
inst_discard  out  1  IF must drop a response arriving this cycle
redir_valid  out  1  redirect request valid
redir_pc  out  32  redirect target
busy  out  1  controller not IDLE
ost_cnt  out  OST_W  outstanding fetch count (debug)

Behaviour:
- States: IDLE, DRAIN, REDIRECT. Encodings live in head.vh.
- event = (exc_oc | ec_eret) & state==IDLE. If both are high, exc_oc wins and target = EXC_VECTOR; otherwise target = cp0_epc.
- flush_pipe = event. It is combinational, so younger instructions in EX never commit.
- On event:
  - redir_pc <= target (registered).
  - state <= DRAIN.
  - disc_cnt <= ost_cnt - if_resp_fire. A same-cycle response belongs to the old stream.
- ost_cnt update:
  - ost_cnt <= ost_cnt + if_req_fire - if_resp_fire every cycle.
  - Assertions: if_req_fire with ost_cnt at max is illegal; if_resp_fire with ost_cnt==0 is illegal.
- inst_discard = (disc_cnt!=0) | (event & ost_cnt!=0).
- DRAIN:
  - Each if_resp_fire decrements disc_cnt.
  - Exit to REDIRECT when next disc_cnt==0 and !dmem_busy.
  - Minimum one cycle in DRAIN.
- REDIRECT:
  - redir_valid=1; redir_pc is held stable.
  - On redir_ready, go to IDLE the next cycle. redir_valid is registered low.
- stall_front = event | state!=IDLE. busy = state!=IDLE.
- if_req_fire while stall_front is high is a protocol error (assertion).
- exc_oc/ec_eret while busy are ignored: EC only holds flushed bubbles. ext_int during DRAIN/REDIRECT is taken after return to IDLE.
- Minimum latency: event at t, redir_valid at t+2, IDLE at t+3 if redir_ready is high at t+2.
- Reset:
  - Values: state=IDLE, ost_cnt=0, disc_cnt=0, redir_pc=0; all 1-bit outputs 0.
  - Reset mid-operation aborts immediately to IDLE; nothing is discarded afterwards, because the bus is reset too.
- Width rules:
  - disc_cnt is OST_W wide and never underflows; decrement is guarded by disc_cnt!=0.
  - ost_cnt wraps are forbidden by assertion, not saturated.

Decomposition:
- head.vh: `EXC_ENTRY`, state encodings (`RC_IDLE`, `RC_DRAIN`, `RC_REDIR`), OST_W default.
- One natural sub-module: fetch_ost_cnt, the outstanding/discard counter pair with its assertions.
- The FSM and the redirect register stay in exc_redirect_ctrl.

Test Plan:
- exc_oc at t, ost_cnt=0, dmem_busy=0, redir_ready=1.
  -> flush_pipe=1 at t; redir_valid=1, redir_pc=0xBFC00380 at t+2; busy=0 at t+3.
- ec_eret, cp0_epc=0x80001234, 2 fetches outstanding, responses at t+3 and t+5.
  -> inst_discard high t..t+5; redir_valid first at t+6 with pc 0x80001234.
- exc_oc and ec_eret in the same cycle, epc=0x80000010.
  -> redir_pc=0xBFC00380.
- dmem_busy held until t+7, no fetches outstanding.
  -> redir_valid rises at t+8; stall_front high throughout.
- redir_ready low for 4 cycles in REDIRECT; a second exc_oc is injected.
  -> redir_valid and redir_pc stable; the second event is ignored; IDLE one cycle after ready.
- Assert reset while in DRAIN with disc_cnt=2.
  -> all outputs 0 asynchronously; a response after reset gives inst_discard=0 and ost_cnt stays 0.
